// File: rtl/lg_nor_pkg.sv
// Shared types and helpers for the round-robin scheduler of the strobed NOR gate.
// Optional grant counter is enabled with LG_NOR_GRANT_CNT_EN.
package lg_nor_pkg;

   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam state_e ST_IDLE  = IDLE;
   localparam state_e ST_GRANT = GRANT;
   localparam state_e ST_DONE  = DONE;

   // First set request found scanning ptr, ptr+1, ... modulo n.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [MAX_REQ-1:0] req,
      input logic [IDX_W-1:0]   ptr,
      input int unsigned        n
   );
      logic [IDX_W-1:0] w;
      logic             hit;
      int unsigned      idx;
      w   = '0;
      hit = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = (32'(ptr) + k) % n;
         if (!hit && k < n && req[idx[IDX_W-1:0]]) begin
            hit = 1'b1;
            w   = idx[IDX_W-1:0];
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/lg_nor_rr_scheduler_gated.sv
// Strobed 4-input NOR model (7425 style): Y = ~(G & (A|B|C|D)).
// Output sits at 1 whenever the strobe is low.
module lg_nor_gated #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             g_i,
   input  logic [WIDTH-1:0] in_i,
   output logic             y_o
);

   assign y_o = ~(g_i & (|in_i));

endmodule

// File: rtl/lg_nor_rr_scheduler.sv
// Round-robin REQ/ACK scheduler sharing one strobed NOR gate among N_REQ users.
// Define LG_NOR_GRANT_CNT_EN to add the saturating GRANT_CNT output.
module lg_nor_rr_scheduler
   import lg_nor_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 4
`ifdef LG_NOR_GRANT_CNT_EN
  ,parameter int unsigned CNT_W = 16
`endif
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [N_REQ-1:0]       REQ,
   input  logic [N_REQ*WIDTH-1:0] DATA,
   output logic [N_REQ-1:0]       GNT,
   output logic [N_REQ-1:0]       ACK,
   output logic                   RESULT,
   output logic                   G_STB,
   output logic                   BUSY
`ifdef LG_NOR_GRANT_CNT_EN
  ,output logic [CNT_W-1:0]       GRANT_CNT
`endif
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] win_q, win_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             result_q, result_d;

   logic [MAX_REQ-1:0] req_pad;
   logic [WIDTH-1:0]   op;
   logic [N_REQ-1:0]   sel;
   logic               gate_y;

   always_comb begin
      req_pad = '0;
      req_pad[N_REQ-1:0] = REQ;
   end

   // Operand mux and one-hot decode of the latched winner.
   always_comb begin
      op  = '0;
      sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_q == IDX_W'(i)) begin
            op     = DATA[i*WIDTH +: WIDTH];
            sel[i] = 1'b1;
         end
      end
   end

   lg_nor_gated #(
      .WIDTH(WIDTH)
   ) u_gate (
      .g_i  (G_STB),
      .in_i (op),
      .y_o  (gate_y)
   );

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      ptr_d    = ptr_q;
      result_d = result_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|REQ) begin
               win_d   = rr_pick(req_pad, ptr_q, N_REQ);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (req_pad[win_q]) begin
               result_d = gate_y;
               state_d  = ST_DONE;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_DONE: begin
            ptr_d   = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         ptr_q    <= '0;
         result_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         ptr_q    <= ptr_d;
         result_q <= result_d;
      end
   end

   assign G_STB  = (state_q == ST_GRANT);
   assign BUSY   = (state_q != ST_IDLE);
   assign GNT    = (state_q == ST_GRANT) ? sel : '0;
   assign ACK    = (state_q == ST_DONE)  ? sel : '0;
   assign RESULT = result_q;

`ifdef LG_NOR_GRANT_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_DONE && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign GRANT_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_lg_nor_rr_scheduler.sv
// Randomized transaction-level bench for lg_nor_rr_scheduler.
// Checks handshake timing, round-robin order, aborts and reset against a model.
module tb_lg_nor_rr_scheduler;

   localparam int N = 4;
   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic [N*W-1:0] data;
   logic [N-1:0] gnt;
   logic [N-1:0] ack;
   logic         result;
   logic         g_stb;
   logic         busy;
`ifdef LG_NOR_GRANT_CNT_EN
   logic [15:0]  grant_cnt;
`endif

   lg_nor_rr_scheduler #(
      .N_REQ(N),
      .WIDTH(W)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .REQ    (req),
      .DATA   (data),
      .GNT    (gnt),
      .ACK    (ack),
      .RESULT (result),
      .G_STB  (g_stb),
      .BUSY   (busy)
`ifdef LG_NOR_GRANT_CNT_EN
     ,.GRANT_CNT(grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: what requesters want, their operands, rr pointer.
   logic [N-1:0] pending;
   logic [W-1:0] dat_m [N];
   int           ptr_m;
   logic         result_m;
   int           cnt_m;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++)
         if (m[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) data[i*W +: W] = dat_m[i];
      req = pending;
   endtask

   task automatic model_reset();
      ptr_m    = 0;
      result_m = 1'b1;
      cnt_m    = 0;
      pending  = '0;
   endtask

   // One arbitration: entered and left at a negedge with the DUT idle.
   task automatic round(input bit abort, input bit add_new);
      int           w;
      logic [N-1:0] nb;
      drive();
      @(posedge clk); @(negedge clk);
      w = pick(pending, ptr_m);
      chk("gnt", 32'(gnt), 32'(1 << w));
      chk("gstb", 32'(g_stb), 32'd1);
      chk("ack_in_grant", 32'(ack), 32'd0);
      nb = add_new ? (4'($urandom_range(0, 15)) & ~pending) : '0;
      for (int i = 0; i < N; i++)
         if (nb[i]) dat_m[i] = 4'($urandom_range(0, 15));
      pending = pending | nb;
      if (abort) pending[w] = 1'b0;
      drive();
      @(posedge clk); @(negedge clk);
      if (abort) begin
         chk("abort_busy", 32'(busy), 32'd0);
         chk("abort_ack", 32'(ack), 32'd0);
         chk("abort_result", 32'(result), 32'(result_m));
         return;
      end
      result_m = ~(|dat_m[w]);
      chk("ack", 32'(ack), 32'(1 << w));
      chk("result", 32'(result), 32'(result_m));
      chk("gnt_in_done", 32'(gnt), 32'd0);
      chk("gstb_in_done", 32'(g_stb), 32'd0);
      pending[w] = 1'b0;
      drive();
      ptr_m = (w + 1) % N;
      if (cnt_m < 65535) cnt_m++;
      @(posedge clk); @(negedge clk);
      chk("ack_pulse", 32'(ack), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
`ifdef LG_NOR_GRANT_CNT_EN
      chk("grant_cnt", 32'(grant_cnt), 32'(cnt_m));
`endif
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      data = '0;
      for (int i = 0; i < N; i++) dat_m[i] = '0;
      model_reset();
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_gstb", 32'(g_stb), 32'd0);
      chk("rst_result", 32'(result), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single requester, both operand polarities.
      pending = 4'b0001; dat_m[0] = 4'b0000;
      round(1'b0, 1'b0);
      pending = 4'b0001; dat_m[0] = 4'b0100;
      round(1'b0, 1'b0);

      // Asynchronous reset while a grant is active.
      pending = 4'b0010; dat_m[1] = 4'b0011;
      drive();
      @(posedge clk); @(negedge clk);
      chk("pre_rst_gnt", 32'(gnt), 32'b0010);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_gstb", 32'(g_stb), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd1);
      model_reset();
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("post_rst_ack", 32'(ack), 32'd0);

      // Full contention from pointer 0, then wrap fairness.
      pending = 4'b1111;
      for (int i = 0; i < N; i++) dat_m[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) round(1'b0, 1'b0);
      pending = 4'b1001;
      round(1'b0, 1'b0);
      round(1'b0, 1'b0);

      // Abort of requester 2 leaves pointer and result alone.
      pending = 4'b0100; dat_m[2] = 4'b0000;
      round(1'b1, 1'b0);
      pending = 4'b1111;
      round(1'b0, 1'b0);

      for (int r = 0; r < 80; r++) begin
         if (pending == '0) begin
            int j;
            j = int'($urandom_range(0, N-1));
            pending[j] = 1'b1;
            dat_m[j] = 4'($urandom_range(0, 15));
         end
         round($urandom_range(0, 4) == 0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
